// File: rtl/edac_pkg.sv
// Shared types and constants for the EDAC read/scrub sequencer.
package edac_pkg;

    localparam logic [7:0] DEFAULT_CRC_POLY = 8'h97;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_DEC,
        S_WB,
        S_RESP,
        S_GAP
    } state_e;

    typedef enum logic {
        GNT_CPU,
        GNT_SCRUB
    } grant_e;

endpackage

// File: rtl/edac_scrub_timer.sv
// Background scrub request generator: idle-cycle interval timer, pending flag and
// wrapping scrub address.
module edac_scrub_timer
    import edac_pkg::*;
#(
    parameter int unsigned AW             = 10,
    parameter int unsigned DEPTH          = 1024,
    parameter int unsigned SCRUB_INTERVAL = 256
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_en,
    input  logic          i_idle,
    input  logic          i_served,
    output logic          o_pend,
    output logic [AW-1:0] o_addr
);

    localparam int unsigned TW = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;

    logic [TW-1:0] r_cnt;
    logic          r_pend;
    logic [AW-1:0] r_addr;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt  <= '0;
            r_pend <= 1'b0;
            r_addr <= '0;
        end else begin
            // Disabling clears only the timer; an already pending scrub is still served.
            if (!i_en) begin
                r_cnt <= '0;
            end else if (i_idle) begin
                if (r_cnt == TW'(SCRUB_INTERVAL - 1)) begin
                    r_cnt  <= '0;
                    r_pend <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + TW'(1);
                end
            end
            if (i_served) begin
                r_pend <= 1'b0;
                r_addr <= (r_addr == AW'(DEPTH - 1)) ? '0 : r_addr + AW'(1);
            end
        end
    end

    assign o_pend = r_pend;
    assign o_addr = r_addr;

endmodule

// File: rtl/edac_access_ctrl.sv
// Sequences the shared EDAC decoder for CPU reads and background scrubs, writes back
// corrected words and keeps saturating correctable/uncorrectable event counts.
module edac_access_ctrl
    import edac_pkg::*;
#(
    parameter int unsigned AW             = 10,
    parameter int unsigned DEPTH          = 1024,
    parameter int unsigned SCRUB_INTERVAL = 256,
    parameter int unsigned DEC_TIMEOUT    = 8,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [7:0]       i_crc_poly_cfg,
    input  logic             i_scrub_en,
    input  logic             i_cpu_req,
    input  logic [AW-1:0]    i_cpu_addr,
    output logic             o_cpu_ack,
    output logic [31:0]      o_cpu_rdata,
    output logic             o_cpu_err,
    output logic             o_mem_rd,
    output logic             o_mem_wr,
    output logic [AW-1:0]    o_mem_addr,
    output logic [31:0]      o_mem_wdata,
    input  logic [31:0]      i_mem_rdata,
    input  logic [31:0]      i_mem_lut_rdata,
    output logic             o_dec_en,
    output logic [31:0]      o_dec_din,
    output logic [31:0]      o_dec_lut_in,
    output logic [7:0]       o_dec_crc_poly,
    input  logic [31:0]      i_dec_dout,
    input  logic             i_dec_valid,
    output logic [CNT_W-1:0] o_corr_cnt,
    output logic [CNT_W-1:0] o_uncorr_cnt,
    output logic             o_busy
);

    localparam int unsigned    WW        = (DEC_TIMEOUT > 1) ? $clog2(DEC_TIMEOUT) : 1;
    localparam logic [WW-1:0]  WAIT_LAST = WW'(DEC_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           r_state;
    grant_e           r_grant;
    logic [AW-1:0]    r_addr;
    logic [7:0]       r_poly;
    logic [31:0]      r_din;
    logic [31:0]      r_lut;
    logic [31:0]      r_dout;
    logic [WW-1:0]    r_wait;
    logic             r_cpu_ack;
    logic [31:0]      r_cpu_rdata;
    logic             r_cpu_err;
    logic             r_mem_rd;
    logic             r_mem_wr;
    logic             r_dec_en;
    logic [CNT_W-1:0] r_corr;
    logic [CNT_W-1:0] r_uncorr;

    logic             w_scrub_pend;
    logic [AW-1:0]    w_scrub_addr;
    logic             w_idle;
    logic             w_scrub_served;
    logic             w_is_cpu;
    logic             w_cpu_win;

    assign w_idle         = (r_state == S_IDLE);
    assign w_is_cpu       = (r_grant == GNT_CPU);
    assign w_scrub_served = (r_state == S_RESP) && (r_grant == GNT_SCRUB);
    // On contention the requester not served last wins, so neither side starves.
    assign w_cpu_win      = i_cpu_req && (!w_scrub_pend || r_grant == GNT_SCRUB);

    edac_scrub_timer #(
        .AW             (AW),
        .DEPTH          (DEPTH),
        .SCRUB_INTERVAL (SCRUB_INTERVAL)
    ) u_scrub_timer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_en     (i_scrub_en),
        .i_idle   (w_idle),
        .i_served (w_scrub_served),
        .o_pend   (w_scrub_pend),
        .o_addr   (w_scrub_addr)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_grant     <= GNT_CPU;
            r_addr      <= '0;
            r_poly      <= '0;
            r_din       <= '0;
            r_lut       <= '0;
            r_dout      <= '0;
            r_wait      <= '0;
            r_cpu_ack   <= 1'b0;
            r_cpu_rdata <= '0;
            r_cpu_err   <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_dec_en    <= 1'b0;
            r_corr      <= '0;
            r_uncorr    <= '0;
        end else begin
            // Strobes are single-cycle: raised on entry to their state, dropped here.
            r_cpu_ack <= 1'b0;
            r_cpu_err <= 1'b0;
            r_mem_rd  <= 1'b0;
            r_mem_wr  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_cpu_win) begin
                        r_grant  <= GNT_CPU;
                        r_addr   <= i_cpu_addr;
                        r_mem_rd <= 1'b1;
                        r_state  <= S_FETCH;
                    end else if (w_scrub_pend) begin
                        r_grant  <= GNT_SCRUB;
                        r_addr   <= w_scrub_addr;
                        r_mem_rd <= 1'b1;
                        r_state  <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_poly  <= i_crc_poly_cfg;
                    r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_din    <= i_mem_rdata;
                    r_lut    <= i_mem_lut_rdata;
                    r_wait   <= '0;
                    r_dec_en <= 1'b1;
                    r_state  <= S_DEC;
                end
                S_DEC: begin
                    if (i_dec_valid) begin
                        r_dout   <= i_dec_dout;
                        r_dec_en <= 1'b0;
                        if (i_dec_dout != r_din) begin
                            if (r_corr != CNT_MAX) r_corr <= r_corr + CNT_W'(1);
                            r_mem_wr <= 1'b1;
                            r_state  <= S_WB;
                        end else begin
                            r_cpu_ack <= w_is_cpu;
                            if (w_is_cpu) r_cpu_rdata <= i_dec_dout;
                            r_state <= S_RESP;
                        end
                    end else if (r_wait == WAIT_LAST) begin
                        // Decoder never answered: pass the raw word through, flagged.
                        if (r_uncorr != CNT_MAX) r_uncorr <= r_uncorr + CNT_W'(1);
                        r_dout    <= r_din;
                        r_dec_en  <= 1'b0;
                        r_cpu_ack <= w_is_cpu;
                        r_cpu_err <= w_is_cpu;
                        if (w_is_cpu) r_cpu_rdata <= r_din;
                        r_state <= S_RESP;
                    end else begin
                        r_wait <= r_wait + WW'(1);
                    end
                end
                S_WB: begin
                    r_cpu_ack <= w_is_cpu;
                    if (w_is_cpu) r_cpu_rdata <= r_dout;
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    r_state <= S_GAP;
                end
                S_GAP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_dec_en <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign o_cpu_ack      = r_cpu_ack;
    assign o_cpu_rdata    = r_cpu_rdata;
    assign o_cpu_err      = r_cpu_err;
    assign o_mem_rd       = r_mem_rd;
    assign o_mem_wr       = r_mem_wr;
    assign o_mem_addr     = r_addr;
    assign o_mem_wdata    = r_dout;
    assign o_dec_en       = r_dec_en;
    assign o_dec_din      = r_din;
    assign o_dec_lut_in   = r_lut;
    assign o_dec_crc_poly = r_poly;
    assign o_corr_cnt     = r_corr;
    assign o_uncorr_cnt   = r_uncorr;
    assign o_busy         = !w_idle;

endmodule

// File: tb/tb_edac_access_ctrl.sv
// Directed bench for edac_access_ctrl with behavioural memory and decoder models.
module tb_edac_access_ctrl;
    import edac_pkg::*;

    localparam int unsigned AW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    crc_poly_cfg;
    logic          scrub_en;
    logic          cpu_req;
    logic [AW-1:0] cpu_addr;
    logic          cpu_ack;
    logic [31:0]   cpu_rdata;
    logic          cpu_err;
    logic          mem_rd;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata = '0;
    logic [31:0]   mem_lut_rdata = '0;
    logic          dec_en;
    logic [31:0]   dec_din;
    logic [31:0]   dec_lut_in;
    logic [7:0]    dec_crc_poly;
    logic [31:0]   dec_dout;
    logic          dec_valid;
    logic [15:0]   corr_cnt;
    logic [15:0]   uncorr_cnt;
    logic          busy;

    edac_access_ctrl #(
        .AW             (AW),
        .DEPTH          (4),
        .SCRUB_INTERVAL (4),
        .DEC_TIMEOUT    (8),
        .CNT_W          (16)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_crc_poly_cfg  (crc_poly_cfg),
        .i_scrub_en      (scrub_en),
        .i_cpu_req       (cpu_req),
        .i_cpu_addr      (cpu_addr),
        .o_cpu_ack       (cpu_ack),
        .o_cpu_rdata     (cpu_rdata),
        .o_cpu_err       (cpu_err),
        .o_mem_rd        (mem_rd),
        .o_mem_wr        (mem_wr),
        .o_mem_addr      (mem_addr),
        .o_mem_wdata     (mem_wdata),
        .i_mem_rdata     (mem_rdata),
        .i_mem_lut_rdata (mem_lut_rdata),
        .o_dec_en        (dec_en),
        .o_dec_din       (dec_din),
        .o_dec_lut_in    (dec_lut_in),
        .o_dec_crc_poly  (dec_crc_poly),
        .i_dec_dout      (dec_dout),
        .i_dec_valid     (dec_valid),
        .o_corr_cnt      (corr_cnt),
        .o_uncorr_cnt    (uncorr_cnt),
        .o_busy          (busy)
    );

    always #5 clk = ~clk;

    // Memory: one-cycle read latency.
    logic [31:0] mem_d [16];
    logic [31:0] mem_l [16];
    always @(posedge clk) begin
        if (mem_rd) begin
            mem_rdata     <= mem_d[mem_addr[3:0]];
            mem_lut_rdata <= mem_l[mem_addr[3:0]];
        end
    end

    // Decoder: corrected word is the LUT word, valid on enable cycle dec_lat (0-based).
    int dec_lat;
    bit dec_never;
    int dec_cnt = 0;
    always @(posedge clk) dec_cnt <= dec_en ? dec_cnt + 1 : 0;
    assign dec_valid = dec_en && !dec_never && (dec_cnt == dec_lat);
    assign dec_dout  = dec_lut_in;

    // Monitors sampled on the falling edge.
    int            ack_n = 0;
    int            wr_n = 0;
    int            rd_n = 0;
    int            bursts = 0;
    logic [AW-1:0] wr_addr = '0;
    logic [31:0]   wr_data = '0;
    logic [AW-1:0] rd_log [64];
    logic [31:0]   din_seen = '0;
    logic [7:0]    poly_seen = '0;
    logic          dec_prev = 1'b0;
    always @(negedge clk) begin
        if (cpu_ack) ack_n <= ack_n + 1;
        if (mem_wr) begin
            wr_n    <= wr_n + 1;
            wr_addr <= mem_addr;
            wr_data <= mem_wdata;
        end
        if (mem_rd) begin
            if (rd_n < 64) rd_log[rd_n[5:0]] <= mem_addr;
            rd_n <= rd_n + 1;
        end
        if (dec_en) begin
            poly_seen <= dec_crc_poly;
            din_seen  <= dec_din;
        end
        if (dec_en && !dec_prev) bursts <= bursts + 1;
        dec_prev <= dec_en;
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_read(input logic [AW-1:0] a, output bit got, output int cyc,
                           output logic [31:0] rd, output logic err);
        cpu_addr = a;
        cpu_req  = 1'b1;
        got = 0;
        cyc = 0;
        rd  = '0;
        err = 1'b0;
        while (!got && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cpu_ack) begin
                got = 1;
                rd  = cpu_rdata;
                err = cpu_err;
            end
        end
        cpu_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic [31:0]   lut;
        logic [7:0]    poly;
        int            lat;
        bit            never;
        logic [31:0]   exp_rdata;
        bit            exp_err;
        bit            exp_wb;
        int            exp_cyc;
    } vec_t;

    vec_t vecs [5];

    initial begin
        bit          got;
        int          cyc;
        logic [31:0] rd;
        logic        err;
        int          exp_corr;
        int          exp_unc;
        int          wr_base;
        int          ack_base;
        int          rd_base;
        int          burst_base;

        // Clean, single-bit error, timeout, late valid, valid on the last allowed cycle.
        vecs[0] = '{10'd5, 32'h0002FA2E, 32'h0002FA2E, DEFAULT_CRC_POLY, 0, 1'b0,
                    32'h0002FA2E, 1'b0, 1'b0, 4};
        vecs[1] = '{10'd6, 32'h000AFA2E, 32'h0002FA2E, DEFAULT_CRC_POLY, 0, 1'b0,
                    32'h0002FA2E, 1'b0, 1'b1, 5};
        vecs[2] = '{10'd7, 32'h12345678, 32'h00000000, DEFAULT_CRC_POLY, 0, 1'b1,
                    32'h12345678, 1'b1, 1'b0, 11};
        vecs[3] = '{10'd3, 32'hDEADBEEF, 32'hDEADBEEF, 8'h1D, 2, 1'b0,
                    32'hDEADBEEF, 1'b0, 1'b0, 6};
        vecs[4] = '{10'd9, 32'h00000001, 32'h00000000, DEFAULT_CRC_POLY, 7, 1'b0,
                    32'h00000000, 1'b0, 1'b1, 12};

        for (int i = 0; i < 16; i++) begin
            mem_d[i] = '0;
            mem_l[i] = '0;
        end
        cpu_req      = 1'b0;
        cpu_addr     = '0;
        scrub_en     = 1'b0;
        crc_poly_cfg = DEFAULT_CRC_POLY;
        dec_lat      = 0;
        dec_never    = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset cpu_ack", 32'(cpu_ack), 32'd0);
        check("reset mem_rd", 32'(mem_rd), 32'd0);
        check("reset mem_wr", 32'(mem_wr), 32'd0);
        check("reset dec_en", 32'(dec_en), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset corr_cnt", 32'(corr_cnt), 32'd0);
        check("reset uncorr_cnt", 32'(uncorr_cnt), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        exp_corr = 0;
        exp_unc  = 0;
        for (int i = 0; i < 5; i++) begin
            mem_d[vecs[i].addr[3:0]] = vecs[i].data;
            mem_l[vecs[i].addr[3:0]] = vecs[i].lut;
            crc_poly_cfg = vecs[i].poly;
            dec_lat      = vecs[i].lat;
            dec_never    = vecs[i].never;
            wr_base      = wr_n;
            do_read(vecs[i].addr, got, cyc, rd, err);
            exp_corr += int'(vecs[i].exp_wb);
            exp_unc  += int'(vecs[i].exp_err);
            check($sformatf("v%0d ack", i), 32'(got), 32'd1);
            check($sformatf("v%0d latency", i), 32'(cyc), 32'(vecs[i].exp_cyc));
            check($sformatf("v%0d rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("v%0d err", i), 32'(err), 32'(vecs[i].exp_err));
            check($sformatf("v%0d wr count", i), 32'(wr_n - wr_base), 32'(vecs[i].exp_wb));
            if (vecs[i].exp_wb) begin
                check($sformatf("v%0d wr addr", i), 32'(wr_addr), 32'(vecs[i].addr));
                check($sformatf("v%0d wr data", i), wr_data, vecs[i].lut);
            end
            check($sformatf("v%0d rd addr", i), 32'(rd_log[rd_n - 1]), 32'(vecs[i].addr));
            check($sformatf("v%0d dec poly", i), 32'(poly_seen), 32'(vecs[i].poly));
            check($sformatf("v%0d dec din", i), din_seen, vecs[i].data);
            check($sformatf("v%0d corr_cnt", i), 32'(corr_cnt), 32'(exp_corr));
            check($sformatf("v%0d uncorr_cnt", i), 32'(uncorr_cnt), 32'(exp_unc));
        end
        dec_lat   = 0;
        dec_never = 1'b0;
        crc_poly_cfg = DEFAULT_CRC_POLY;

        // Contention: scrub becomes pending as the CPU request arrives; last grant was CPU.
        mem_d[0]   = 32'hA5A50000;
        mem_l[0]   = 32'hA5A50000;
        rd_base    = rd_n;
        burst_base = bursts;
        scrub_en   = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        cpu_addr = 10'd5;
        cpu_req  = 1'b1;
        @(posedge clk);
        #1;
        scrub_en = 1'b0;
        got = 0;
        cyc = 0;
        rd  = '0;
        while (!got && cyc < 40) begin
            if (cpu_ack) begin
                got = 1;
                rd  = cpu_rdata;
            end else begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        cpu_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("contention ack", 32'(got), 32'd1);
        check("contention rdata", rd, 32'h0002FA2E);
        check("contention reads", 32'(rd_n - rd_base), 32'd2);
        check("contention first addr", 32'(rd_log[rd_base]), 32'd0);
        check("contention second addr", 32'(rd_log[rd_base + 1]), 32'd5);
        check("contention dec_en bursts", 32'(bursts - burst_base), 32'd2);

        // Reset while waiting in the decode state.
        dec_never = 1'b1;
        cpu_addr  = 10'd7;
        cpu_req   = 1'b1;
        cyc = 0;
        while (!dec_en && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("midreset reached decode", 32'(dec_en), 32'd1);
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        rst     = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        ack_base = ack_n;
        wr_base  = wr_n;
        check("midreset dec_en", 32'(dec_en), 32'd0);
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset cpu_ack", 32'(cpu_ack), 32'd0);
        check("midreset mem_wr", 32'(mem_wr), 32'd0);
        check("midreset corr_cnt", 32'(corr_cnt), 32'd0);
        check("midreset uncorr_cnt", 32'(uncorr_cnt), 32'd0);
        repeat (12) @(posedge clk);
        #1;
        check("midreset later acks", 32'(ack_n - ack_base), 32'd0);
        check("midreset later writes", 32'(wr_n - wr_base), 32'd0);
        dec_never = 1'b0;

        // Scrub wrap with DEPTH=4: addresses 0,1,2,3,0.
        for (int i = 0; i < 4; i++) begin
            mem_d[i] = 32'h1000_0000 + 32'(i);
            mem_l[i] = 32'h1000_0000 + 32'(i);
        end
        rd_base  = rd_n;
        wr_base  = wr_n;
        ack_base = ack_n;
        scrub_en = 1'b1;
        cyc = 0;
        while ((rd_n - rd_base) < 5 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        scrub_en = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("wrap scrub count", 32'(rd_n - rd_base), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("wrap addr %0d", i), 32'(rd_log[rd_base + i]), 32'(i % 4));
        end
        check("wrap writes", 32'(wr_n - wr_base), 32'd0);
        check("wrap acks", 32'(ack_n - ack_base), 32'd0);
        check("wrap corr_cnt", 32'(corr_cnt), 32'd0);
        check("wrap busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
